// File: rtl/core_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : core_mem_pkg                                                 |
// | Description : Shared widths, FSM state encoding and parity helper for the  |
// |               multi-port core memory.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package core_mem_pkg;

    // Membus field widths
    localparam int WORD_W  = 36;
    localparam int MA_W    = 15;
    localparam int SEL_W   = 4;

    // Shared down-counter width; every timed phase loads (length - 1)
    localparam int CNT_W   = 16;

    // Memory cycle state encoding
    localparam int STATE_W = 4;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_GRANT    = 4'd1;
    localparam state_t S_READ     = 4'd2;
    localparam state_t S_MBHOLD   = 4'd3;
    localparam state_t S_WAIT_WRS = 4'd4;
    localparam state_t S_WRITE    = 4'd5;
    localparam state_t S_RECOVER  = 4'd6;
    localparam state_t S_STOP     = 4'd7;

    // Parity bit that makes {parity, data} carry an odd number of ones
    function automatic logic odd_par(input logic [WORD_W-1:0] d);
        return ~(^d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_mem_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : core_mem_mp_if                                               |
// | Description : Membus bundle between NPORTS processors and the core memory. |
// |               master = processor side, slave = memory side.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface core_mem_mp_if
    import core_mem_pkg::*;
#(
    parameter int NPORTS = 4
);
    logic [NPORTS-1:0]        membus_rq_cyc;
    logic [NPORTS-1:0]        membus_rd_rq;
    logic [NPORTS-1:0]        membus_wr_rq;
    logic [NPORTS-1:0]        membus_wr_rs;
    logic [NPORTS-1:0]        membus_fmc_select;
    logic [NPORTS*SEL_W-1:0]  membus_sel;
    logic [NPORTS*MA_W-1:0]   membus_ma;
    logic [NPORTS*WORD_W-1:0] membus_mb_in;
    logic [NPORTS-1:0]        membus_addr_ack;
    logic [NPORTS-1:0]        membus_rd_rs;
    logic [NPORTS*WORD_W-1:0] membus_mb_out;

    modport master (
        output membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
               membus_fmc_select, membus_sel, membus_ma, membus_mb_in,
        input  membus_addr_ack, membus_rd_rs, membus_mb_out
    );

    modport slave (
        input  membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
               membus_fmc_select, membus_sel, membus_ma, membus_mb_in,
        output membus_addr_ack, membus_rd_rs, membus_mb_out
    );

endinterface
`default_nettype wire

// File: rtl/core_mem_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : core_mem_rr_arb                                              |
// | Description : Round-robin arbiter. Grants the lowest requesting index at or |
// |               after the pointer; advance moves the pointer past the winner.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module core_mem_rr_arb #(
    parameter  int NPORTS = 4,
    localparam int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [NPORTS-1:0] req,
    input  wire logic              advance,
    output logic      [NPORTS-1:0] grant
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic          w_vld;

    // Search the request vector starting at the pointer, wrapping once
    always_comb begin
        grant = '0;
        w_idx = '0;
        w_vld = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (!w_vld && req[(int'(r_ptr) + k) % NPORTS]) begin
                w_vld = 1'b1;
                w_idx = PW'((int'(r_ptr) + k) % NPORTS);
                grant[(int'(r_ptr) + k) % NPORTS] = 1'b1;
            end
        end
    end

    // Pointer moves to the port after the one just granted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance && w_vld) begin
            r_ptr <= (w_idx == PW'(NPORTS - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_mem_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : core_mem_mp                                                  |
// | Description : Multi-port 2^AW x 36-bit core memory. Each cycle is a        |
// |               destructive read followed by a restore; processors may       |
// |               replace the restored word (write / read-modify-write).       |
// |               Optional macro CORE_PARITY_EN: 37-bit array with odd parity  |
// |               and a sticky parity_err output.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module core_mem_mp
    import core_mem_pkg::*;
#(
    parameter int                    NPORTS  = 4,
    parameter int                    AW      = 14,
    parameter logic [NPORTS*4-1:0]   MEMSEL  = '0,
    parameter int                    T_ACK   = 2,
    parameter int                    T_RD    = 10,
    parameter int                    MB_HOLD = 3,
    parameter int                    T_WR    = 10,
    parameter int                    T_REC   = 6
) (
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic      sw_single_step,
    input  wire logic      sw_restart,
    core_mem_mp_if.slave   membus,
    output logic           busy,
    output logic           stopped
`ifdef CORE_PARITY_EN
    ,
    output logic           parity_err
`endif
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
`ifdef CORE_PARITY_EN
    localparam int ARR_W = WORD_W + 1;
`else
    localparam int ARR_W = WORD_W;
`endif

    localparam logic [CNT_W-1:0] c_ACK_LD  = CNT_W'(T_ACK - 1);
    localparam logic [CNT_W-1:0] c_RD_LD   = CNT_W'(T_RD - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LD = CNT_W'(MB_HOLD - 1);
    localparam logic [CNT_W-1:0] c_WR_LD   = CNT_W'(T_WR - 1);
    localparam logic [CNT_W-1:0] c_REC_LD  = CNT_W'(T_REC - 1);

    // Core array: never reset, contents survive reset
    logic [ARR_W-1:0]         r_core [2**AW];

    state_t                   r_state, w_state_nx;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nx;
    logic [PW-1:0]            r_port;
    logic [AW-1:0]            r_ma;
    logic                     r_rd, r_wr;
    logic [WORD_W-1:0]        r_cmb;
    logic                     r_restart_q;
    logic [NPORTS-1:0]        r_addr_ack;
    logic [NPORTS-1:0]        r_rd_rs;
    logic [NPORTS*WORD_W-1:0] r_mb_out;

    logic [NPORTS-1:0]        w_req_valid;
    logic [NPORTS-1:0]        w_grant;
    logic [PW-1:0]            w_grant_idx;
    logic                     w_start, w_ack, w_strobe, w_hold_end, w_load_mb, w_commit;
    logic                     w_cnt_zero;
    logic [ARR_W-1:0]         w_rd_word, w_wr_word;
    logic [WORD_W-1:0]        w_sa;
    logic                     w_ma_unused;

    // A port requests only when its select field matches and fast memory is not selected
    for (genvar p = 0; p < NPORTS; p++) begin : g_req
        assign w_req_valid[p] = membus.membus_rq_cyc[p] & ~membus.membus_fmc_select[p] &
                                (membus.membus_sel[SEL_W*p +: SEL_W] == MEMSEL[SEL_W*p +: SEL_W]);
    end

    core_mem_rr_arb #(.NPORTS(NPORTS)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (w_req_valid),
        .advance (w_start),
        .grant   (w_grant)
    );

    // One-hot grant to port number
    always_comb begin
        w_grant_idx = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_grant[p]) w_grant_idx = PW'(p);
        end
    end

    // Address bits above AW are ignored
    assign w_ma_unused = ^membus.membus_ma;

    assign w_rd_word  = r_core[r_ma];
    assign w_sa       = w_rd_word[WORD_W-1:0];
`ifdef CORE_PARITY_EN
    assign w_wr_word  = {odd_par(r_cmb), r_cmb};
`else
    assign w_wr_word  = r_cmb;
`endif
    assign w_cnt_zero = (r_cnt == '0);

    // State register and shared phase timer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Next state, timer reload and datapath strobes
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
        w_start    = 1'b0;
        w_ack      = 1'b0;
        w_strobe   = 1'b0;
        w_hold_end = 1'b0;
        w_load_mb  = 1'b0;
        w_commit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_req_valid) begin
                    w_start    = 1'b1;
                    w_state_nx = S_GRANT;
                    w_cnt_nx   = c_ACK_LD;
                end
            end
            S_GRANT: begin
                if (w_cnt_zero) begin
                    w_ack      = 1'b1;
                    w_state_nx = S_READ;
                    w_cnt_nx   = c_RD_LD;
                end
            end
            S_READ: begin
                if (w_cnt_zero) begin
                    w_strobe = 1'b1;
                    if (r_rd) begin
                        w_state_nx = S_MBHOLD;
                        w_cnt_nx   = c_HOLD_LD;
                    end else if (r_wr) begin
                        w_state_nx = S_WAIT_WRS;
                    end else begin
                        w_state_nx = S_WRITE;
                        w_cnt_nx   = c_WR_LD;
                    end
                end
            end
            S_MBHOLD: begin
                if (w_cnt_zero) begin
                    w_hold_end = 1'b1;
                    if (r_wr) begin
                        w_state_nx = S_WAIT_WRS;
                    end else begin
                        w_state_nx = S_WRITE;
                        w_cnt_nx   = c_WR_LD;
                    end
                end
            end
            S_WAIT_WRS: begin
                if (membus.membus_wr_rs[r_port]) begin
                    w_load_mb  = 1'b1;
                    w_state_nx = S_WRITE;
                    w_cnt_nx   = c_WR_LD;
                end
            end
            S_WRITE: begin
                if (w_cnt_zero) begin
                    w_commit   = 1'b1;
                    w_state_nx = S_RECOVER;
                    w_cnt_nx   = c_REC_LD;
                end
            end
            S_RECOVER: begin
                if (w_cnt_zero) w_state_nx = sw_single_step ? S_STOP : S_IDLE;
            end
            S_STOP: begin
                if (sw_restart && !r_restart_q) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Cycle latches, bus pulses and the memory buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_port      <= '0;
            r_ma        <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_cmb       <= '0;
            r_restart_q <= 1'b0;
            r_addr_ack  <= '0;
            r_rd_rs     <= '0;
            r_mb_out    <= '0;
        end else begin
            r_restart_q <= sw_restart;
            r_addr_ack  <= '0;
            r_rd_rs     <= '0;
            if (w_start) begin
                r_port <= w_grant_idx;
                r_ma   <= membus.membus_ma[MA_W*int'(w_grant_idx) +: AW];
            end
            if (w_ack) begin
                r_addr_ack[r_port] <= 1'b1;
                r_rd               <= membus.membus_rd_rq[r_port];
                r_wr               <= membus.membus_wr_rq[r_port];
            end
            if (w_strobe) begin
                // A pure write clears the buffer; otherwise the sensed word is restored
                r_cmb <= (r_wr && !r_rd) ? '0 : w_sa;
                if (r_rd) begin
                    r_rd_rs[r_port]                          <= 1'b1;
                    r_mb_out[WORD_W*int'(r_port) +: WORD_W] <= w_sa;
                end
            end
            if (w_hold_end) r_mb_out <= '0;
            if (w_load_mb)  r_cmb    <= membus.membus_mb_in[WORD_W*int'(r_port) +: WORD_W];
        end
    end

    // Restore / write into the core at the end of the write phase
    always_ff @(posedge clk) begin
        if (!reset && w_commit) r_core[r_ma] <= w_wr_word;
    end

`ifdef CORE_PARITY_EN
    // Sticky parity error, checked when the sense amps are strobed
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else if (w_strobe && !(^w_rd_word)) begin
            parity_err <= 1'b1;
        end
    end
`endif

    assign membus.membus_addr_ack = r_addr_ack;
    assign membus.membus_rd_rs    = r_rd_rs;
    assign membus.membus_mb_out   = r_mb_out;
    assign busy    = (r_state != S_IDLE) && (r_state != S_STOP);
    assign stopped = (r_state == S_STOP);

endmodule
`default_nettype wire

// File: tb/tb_core_mem_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_core_mem_mp                                               |
// | Description : Directed self-checking bench for core_mem_mp with a          |
// |               scoreboard of expected acks and read data. Optional macro    |
// |               CORE_PARITY_EN adds the parity-error step.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_core_mem_mp;
    import core_mem_pkg::*;

    localparam int NP      = 4;
    localparam int T_ACK   = 2;
    localparam int T_RD    = 10;
    localparam int MB_HOLD = 3;
    localparam int T_WR    = 10;
    localparam int T_REC   = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sw_single_step = 1'b0;
    logic sw_restart = 1'b0;
    logic busy, stopped;
`ifdef CORE_PARITY_EN
    logic parity_err;
`endif

    always #5 clk = ~clk;

    core_mem_mp_if #(.NPORTS(NP)) membus ();

    core_mem_mp #(
        .NPORTS(NP), .AW(14), .MEMSEL('0), .T_ACK(T_ACK), .T_RD(T_RD),
        .MB_HOLD(MB_HOLD), .T_WR(T_WR), .T_REC(T_REC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sw_single_step (sw_single_step),
        .sw_restart     (sw_restart),
        .membus         (membus),
        .busy           (busy),
        .stopped        (stopped)
`ifdef CORE_PARITY_EN
        ,
        .parity_err     (parity_err)
`endif
    );

    typedef struct {
        int          port;
        logic [35:0] data;
    } rd_exp_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          q_ack[$];
    rd_exp_t     q_rd[$];
    logic [35:0] mem_model [int];

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack and every read-data pulse must match the next expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (membus.membus_addr_ack != '0) begin
                if (q_ack.size() == 0) begin
                    check("unexpected_ack", 160'(membus.membus_addr_ack), '0);
                end else begin
                    int e;
                    e = q_ack.pop_front();
                    check("ack_port", 160'(membus.membus_addr_ack), 160'(1) << e);
                end
            end
            if (membus.membus_rd_rs != '0) begin
                if (q_rd.size() == 0) begin
                    check("unexpected_rd_rs", 160'(membus.membus_rd_rs), '0);
                end else begin
                    rd_exp_t r;
                    r = q_rd.pop_front();
                    check("rd_rs_port", 160'(membus.membus_rd_rs), 160'(1) << r.port);
                    check("rd_data", 160'(membus.membus_mb_out), 160'(r.data) << (36 * r.port));
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        bit got = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (!busy) got = 1;
        end
        check(tag, 160'(got), 160'(1));
    endtask

    // One processor memory cycle on port p
    task automatic do_cycle(input int p, input int addr, input bit rd, input bit wr,
                            input logic [35:0] wdata, input bit early_rs,
                            output int ack_lat, output int rs_lat, output int hold_len);
        bit          got;
        int          cyc;
        logic [35:0] exp_data;
        ack_lat  = -1;
        rs_lat   = -1;
        hold_len = 0;
        exp_data = mem_model.exists(addr) ? mem_model[addr] : '0;
        q_ack.push_back(p);
        if (rd) begin
            rd_exp_t r;
            r.port = p;
            r.data = exp_data;
            q_rd.push_back(r);
        end
        membus.membus_ma[15*p +: 15] = 15'(addr);
        membus.membus_rd_rq[p]  = rd;
        membus.membus_wr_rq[p]  = wr;
        membus.membus_rq_cyc[p] = 1'b1;
        got = 0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (membus.membus_addr_ack[p]) got = 1;
        end
        check("ack_timeout", 160'(got), 160'(1));
        ack_lat = cyc;
        membus.membus_rq_cyc[p] = 1'b0;
        cyc = 0;
        if (early_rs) begin
            // Restart offered during the read phase must be ignored
            repeat (2) @(negedge clk);
            membus.membus_mb_in[36*p +: 36] = 36'o111111111111;
            membus.membus_wr_rs[p] = 1'b1;
            @(negedge clk);
            membus.membus_wr_rs[p] = 1'b0;
            cyc = 3;
        end
        if (rd) begin
            got = 0;
            while (!got && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (membus.membus_rd_rs[p]) got = 1;
            end
            check("rd_rs_timeout", 160'(got), 160'(1));
            rs_lat = cyc;
            while (membus.membus_mb_out[36*p +: 36] === exp_data && hold_len < 20) begin
                hold_len++;
                @(negedge clk);
                cyc++;
            end
        end
        if (wr) begin
            while (cyc < T_RD + MB_HOLD + 3) begin
                @(negedge clk);
                cyc++;
            end
            membus.membus_mb_in[36*p +: 36] = wdata;
            membus.membus_wr_rs[p] = 1'b1;
            @(negedge clk);
            membus.membus_wr_rs[p] = 1'b0;
            mem_model[addr] = wdata;
        end
        membus.membus_rd_rq[p] = 1'b0;
        membus.membus_wr_rq[p] = 1'b0;
        wait_idle("cycle_end_timeout");
    endtask

    task automatic wait_acks_drained(input string tag);
        bit got = 0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (q_ack.size() == 0) got = 1;
        end
        check(tag, 160'(got), 160'(1));
    endtask

    initial begin
        int a, b, c;
        membus.membus_rq_cyc     = '0;
        membus.membus_rd_rq      = '0;
        membus.membus_wr_rq      = '0;
        membus.membus_wr_rs      = '0;
        membus.membus_fmc_select = '0;
        membus.membus_sel        = '0;
        membus.membus_ma         = '0;
        membus.membus_mb_in      = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",     160'(busy), '0);
        check("rst_stopped",  160'(stopped), '0);
        check("rst_addr_ack", 160'(membus.membus_addr_ack), '0);
        check("rst_rd_rs",    160'(membus.membus_rd_rs), '0);
        check("rst_mb_out",   160'(membus.membus_mb_out), '0);
        reset = 1'b0;
        @(negedge clk);

        // Preload then read back with timing checks
        do_cycle(0, 'o17, 0, 1, 36'o123456701234, 0, a, b, c);
        do_cycle(0, 'o17, 1, 0, '0, 0, a, b, c);
        check("ack_latency", 160'(a), 160'(1 + T_ACK));
        check("rd_latency",  160'(b), 160'(T_RD));
        check("mb_hold_len", 160'(c), 160'(MB_HOLD));
        do_cycle(3, 'o17, 1, 0, '0, 0, a, b, c);

        // Write with an early (ignored) restart, read from another port
        do_cycle(1, 'o20, 0, 1, 36'o777000777000, 1, a, b, c);
        do_cycle(2, 'o20, 1, 0, '0, 0, a, b, c);

        // Read-modify-write returns old data, then stores new
        do_cycle(2, 'o5, 0, 1, 36'o555, 0, a, b, c);
        do_cycle(2, 'o5, 1, 1, 36'o1, 0, a, b, c);
        do_cycle(0, 'o5, 1, 0, '0, 0, a, b, c);

        // Plain restore cycle leaves the word intact and gives no rd_rs
        do_cycle(3, 'o5, 0, 0, '0, 0, a, b, c);
        do_cycle(1, 'o5, 1, 0, '0, 0, a, b, c);

`ifdef CORE_PARITY_EN
        check("parity_clean", 160'(parity_err), '0);
        dut.r_core[15] = dut.r_core[15] ^ 37'd1;
        mem_model['o17] = mem_model['o17] ^ 36'd1;
        do_cycle(0, 'o17, 1, 0, '0, 0, a, b, c);
        check("parity_err", 160'(parity_err), 160'(1));
`endif

        // Single-step: stop after one cycle, pending request waits for restart
        sw_single_step = 1'b1;
        do_cycle(0, 'o17, 0, 0, '0, 0, a, b, c);
        check("ss_stopped", 160'(stopped), 160'(1));
        check("ss_not_busy", 160'(busy), '0);
        membus.membus_rq_cyc[1] = 1'b1;
        repeat (6) @(negedge clk);
        check("ss_still_stopped", 160'(stopped), 160'(1));
        sw_single_step = 1'b0;
        sw_restart = 1'b1;
        @(negedge clk);
        check("ss_left_stop", 160'(stopped), '0);
        do_cycle(1, 'o20, 1, 0, '0, 0, a, b, c);
        sw_restart = 1'b0;

        // Reset while waiting for write restart
        q_ack.push_back(2);
        membus.membus_ma[30 +: 15] = 15'o30;
        membus.membus_wr_rq[2]  = 1'b1;
        membus.membus_rq_cyc[2] = 1'b1;
        wait_acks_drained("wrs_ack_timeout");
        membus.membus_rq_cyc[2] = 1'b0;
        repeat (T_RD + 4) @(negedge clk);
        check("wait_wrs_busy", 160'(busy), 160'(1));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",    160'(busy), '0);
        check("mid_rst_stopped", 160'(stopped), '0);
        check("mid_rst_ack",     160'(membus.membus_addr_ack), '0);
        check("mid_rst_rd_rs",   160'(membus.membus_rd_rs), '0);
        check("mid_rst_mb_out",  160'(membus.membus_mb_out), '0);
        reset = 1'b0;
        membus.membus_wr_rq[2] = 1'b0;
        @(negedge clk);

        // Round robin with all ports requesting continuously
        q_ack.push_back(0); q_ack.push_back(1); q_ack.push_back(2);
        q_ack.push_back(3); q_ack.push_back(0);
        membus.membus_rq_cyc = '1;
        wait_acks_drained("arb_all_timeout");
        membus.membus_rq_cyc = '0;
        wait_idle("arb_all_idle");

        // Fast-memory and select mismatch block ports 1 and 2
        membus.membus_fmc_select[1] = 1'b1;
        membus.membus_sel[8 +: 4]   = 4'h3;
        q_ack.push_back(3); q_ack.push_back(0); q_ack.push_back(3); q_ack.push_back(0);
        membus.membus_rq_cyc = '1;
        wait_acks_drained("arb_mask_timeout");
        membus.membus_rq_cyc = '0;
        wait_idle("arb_mask_idle");
        membus.membus_fmc_select = '0;
        membus.membus_sel = '0;

        check("q_ack_drained", 160'(q_ack.size()), '0);
        check("q_rd_drained",  160'(q_rd.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
